// File: rtl/csr_block_mc.sv
// rtl/csr_block_mc.sv - multi-channel test-control CSR block (Avalon-MM slave); define CSR_IRQ_EN for irq_o and IRQ_MASK
module csr_block_mc #(
  parameter  int CH_NUM    = 2,
  parameter  int PARAM_NUM = 4,
  parameter  int RES_NUM   = 4,
  parameter  int DATA_W    = 32,
  localparam int CH_AW     = (CH_NUM > 1) ? $clog2(CH_NUM) : 1,
  localparam int ADDR_W    = CH_AW + 4,
  localparam int BE_W      = DATA_W / 8
) (
  input  logic                                clk_sys_i,
  input  logic                                rst_n_i,
  input  logic                                read_i,
  input  logic                                write_i,
  input  logic [ADDR_W-1:0]                   address_i,
  input  logic [DATA_W-1:0]                   writedata_i,
  input  logic [BE_W-1:0]                     byteenable_i,
  output logic                                readdatavalid_o,
  output logic [DATA_W-1:0]                   readdata_o,
  output logic [CH_NUM-1:0]                   start_o,
  output logic [CH_NUM-1:0]                   abort_o,
  output logic [CH_NUM*PARAM_NUM*DATA_W-1:0]  test_param_o,
  input  logic [CH_NUM-1:0]                   test_finished_i,
  input  logic [CH_NUM*RES_NUM*DATA_W-1:0]    test_result_i
`ifdef CSR_IRQ_EN
  ,
  output logic                                irq_o
`endif
);

  // Channel indices at or above this limit decode to nothing.
  localparam logic [CH_AW:0] CH_LIM = (CH_AW+1)'(CH_NUM);

  // Register storage
  logic [DATA_W-1:0] param_q  [CH_NUM][PARAM_NUM];
  logic [DATA_W-1:0] result_q [CH_NUM][RES_NUM];
  logic [CH_NUM-1:0] busy_q;
  logic [CH_NUM-1:0] done_q;
  logic [CH_NUM-1:0] aborted_q;
`ifdef CSR_IRQ_EN
  logic [CH_NUM-1:0] mask_q;
`endif

  // Finish edge detection
  logic [CH_NUM-1:0] fin_q1;
  logic [CH_NUM-1:0] fin_q2;
  logic [CH_NUM-1:0] fin_rise;

  // Write-side decode
  logic [CH_AW-1:0]  wr_ch;
  logic [3:0]        wr_off;
  logic              wr_ch_ok;
  logic [CH_NUM-1:0] ch_hit;
  logic [CH_NUM-1:0] abort_req;
  logic [CH_NUM-1:0] do_start;
  logic [CH_NUM-1:0] do_abort;
  logic [CH_NUM-1:0] do_finish;

  // Read pipeline: stage 1 holds the accepted address, stage 2 is the output register
  logic              rd_acc;
  logic              rd_pend_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [CH_AW-1:0]  rd_ch;
  logic [3:0]        rd_off;
  logic              rd_ch_ok;
  logic [DATA_W-1:0] rd_mux;
  logic [CH_NUM-1:0] clr_stat;

  assign wr_ch    = address_i[ADDR_W-1:4];
  assign wr_off   = address_i[3:0];
  assign wr_ch_ok = ({1'b0, wr_ch} < CH_LIM);
  assign rd_ch    = rd_addr_q[ADDR_W-1:4];
  assign rd_off   = rd_addr_q[3:0];
  assign rd_ch_ok = ({1'b0, rd_ch} < CH_LIM);
  assign fin_rise = fin_q1 & ~fin_q2;

  // A simultaneous write takes the bus cycle, so the read is simply not accepted.
  assign rd_acc = read_i & ~write_i;

  // Flatten the parameter registers channel-major onto the output bus.
  for (genvar gc = 0; gc < CH_NUM; gc++) begin : g_ch
    for (genvar gi = 0; gi < PARAM_NUM; gi++) begin : g_par
      assign test_param_o[(gc*PARAM_NUM+gi)*DATA_W +: DATA_W] = param_q[gc][gi];
    end
  end

  // Per-channel command decode: abort beats start, and a finish edge loses to an abort.
  always_comb begin
    ch_hit    = '0;
    abort_req = '0;
    do_start  = '0;
    do_abort  = '0;
    do_finish = '0;
    clr_stat  = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      ch_hit[c]    = write_i & wr_ch_ok & (wr_ch == CH_AW'(c));
      abort_req[c] = ch_hit[c] & (wr_off == 4'h0) & byteenable_i[0] & writedata_i[1];
      do_start[c]  = ch_hit[c] & (wr_off == 4'h0) & byteenable_i[0] & writedata_i[0]
                     & ~writedata_i[1] & ~busy_q[c];
      do_abort[c]  = abort_req[c] & busy_q[c];
      do_finish[c] = fin_rise[c] & busy_q[c] & ~abort_req[c];
      clr_stat[c]  = rd_pend_q & rd_ch_ok & (rd_ch == CH_AW'(c)) & (rd_off == 4'h1);
    end
  end

  // Read data multiplexer, evaluated in the cycle after the read was accepted.
  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      if (rd_ch_ok && (rd_ch == CH_AW'(c))) begin
        if (rd_off == 4'h1) begin
          rd_mux = DATA_W'({aborted_q[c], done_q[c], busy_q[c]});
        end
`ifdef CSR_IRQ_EN
        if (rd_off == 4'h2) begin
          rd_mux = DATA_W'(mask_q[c]);
        end
`endif
        for (int i = 0; i < PARAM_NUM; i++) begin
          if (rd_off == 4'(4 + i)) begin
            rd_mux = param_q[c][i];
          end
        end
        for (int j = 0; j < RES_NUM; j++) begin
          if (rd_off == 4'(8 + j)) begin
            rd_mux = result_q[c][j];
          end
        end
      end
    end
  end

  // Two-stage read pipeline giving a fixed two-cycle latency.
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_pend_q       <= 1'b0;
      rd_addr_q       <= '0;
      readdatavalid_o <= 1'b0;
      readdata_o      <= '0;
    end else begin
      rd_pend_q       <= rd_acc;
      readdatavalid_o <= rd_pend_q;
      if (rd_acc) begin
        rd_addr_q <= address_i;
      end
      if (rd_pend_q) begin
        readdata_o <= rd_mux;
      end
    end
  end

  // Channel state: strobes, busy, and sticky done/aborted flags.
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fin_q1    <= '0;
      fin_q2    <= '0;
      start_o   <= '0;
      abort_o   <= '0;
      busy_q    <= '0;
      done_q    <= '0;
      aborted_q <= '0;
    end else begin
      fin_q1  <= test_finished_i;
      fin_q2  <= fin_q1;
      start_o <= do_start;
      abort_o <= do_abort;
      for (int c = 0; c < CH_NUM; c++) begin
        if (do_abort[c] || do_finish[c]) begin
          busy_q[c] <= 1'b0;
        end else if (do_start[c]) begin
          busy_q[c] <= 1'b1;
        end
        // A set event in the same cycle as the STATUS read keeps the flag.
        if (do_start[c]) begin
          done_q[c] <= 1'b0;
        end else if (do_finish[c]) begin
          done_q[c] <= 1'b1;
        end else if (clr_stat[c]) begin
          done_q[c] <= 1'b0;
        end
        if (do_start[c]) begin
          aborted_q[c] <= 1'b0;
        end else if (do_abort[c]) begin
          aborted_q[c] <= 1'b1;
        end else if (clr_stat[c]) begin
          aborted_q[c] <= 1'b0;
        end
      end
    end
  end

  // Parameter registers, byte-masked and frozen while the channel is busy.
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int c = 0; c < CH_NUM; c++) begin
        for (int i = 0; i < PARAM_NUM; i++) begin
          param_q[c][i] <= '0;
        end
      end
    end else begin
      for (int c = 0; c < CH_NUM; c++) begin
        for (int i = 0; i < PARAM_NUM; i++) begin
          if (ch_hit[c] && !busy_q[c] && (wr_off == 4'(4 + i))) begin
            for (int b = 0; b < BE_W; b++) begin
              if (byteenable_i[b]) begin
                param_q[c][i][8*b +: 8] <= writedata_i[8*b +: 8];
              end
            end
          end
        end
      end
    end
  end

  // Result capture on an accepted finish edge; held until the next one.
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int c = 0; c < CH_NUM; c++) begin
        for (int j = 0; j < RES_NUM; j++) begin
          result_q[c][j] <= '0;
        end
      end
    end else begin
      for (int c = 0; c < CH_NUM; c++) begin
        if (do_finish[c]) begin
          for (int j = 0; j < RES_NUM; j++) begin
            result_q[c][j] <= test_result_i[(c*RES_NUM+j)*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

`ifdef CSR_IRQ_EN
  // Interrupt mask registers and the registered interrupt output.
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mask_q <= '0;
      irq_o  <= 1'b0;
    end else begin
      irq_o <= |((done_q | aborted_q) & mask_q);
      for (int c = 0; c < CH_NUM; c++) begin
        if (ch_hit[c] && (wr_off == 4'h2) && byteenable_i[0]) begin
          mask_q[c] <= writedata_i[0];
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_csr_block_mc.sv
// tb/tb_csr_block_mc.sv - scoreboard testbench for csr_block_mc (optionally built with CSR_IRQ_EN)
module tb_csr_block_mc;

  logic         clk_sys_i = 1'b0;
  logic         rst_n_i;
  logic         read_i;
  logic         write_i;
  logic [4:0]   address_i;
  logic [31:0]  writedata_i;
  logic [3:0]   byteenable_i;
  logic         readdatavalid_o;
  logic [31:0]  readdata_o;
  logic [1:0]   start_o;
  logic [1:0]   abort_o;
  logic [255:0] test_param_o;
  logic [1:0]   test_finished_i;
  logic [255:0] test_result_i;
`ifdef CSR_IRQ_EN
  logic         irq_o;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] exp_q [$];

  csr_block_mc dut (
    .clk_sys_i       (clk_sys_i),
    .rst_n_i         (rst_n_i),
    .read_i          (read_i),
    .write_i         (write_i),
    .address_i       (address_i),
    .writedata_i     (writedata_i),
    .byteenable_i    (byteenable_i),
    .readdatavalid_o (readdatavalid_o),
    .readdata_o      (readdata_o),
    .start_o         (start_o),
    .abort_o         (abort_o),
    .test_param_o    (test_param_o),
    .test_finished_i (test_finished_i),
    .test_result_i   (test_result_i)
`ifdef CSR_IRQ_EN
    ,
    .irq_o           (irq_o)
`endif
  );

  always #5 clk_sys_i = ~clk_sys_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_sys_i);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    address_i    = a;
    writedata_i  = d;
    byteenable_i = be;
    write_i      = 1'b1;
    tick();
    write_i      = 1'b0;
  endtask

  // Issue one read, wait (bounded) for its data, and pop the matching expectation.
  task automatic rd_pop(input logic [4:0] a, input logic [31:0] e,
                        output bit got, output logic [31:0] act, output logic [31:0] expv);
    exp_q.push_back(e);
    address_i = a;
    read_i    = 1'b1;
    tick();
    read_i    = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      if (readdatavalid_o) got = 1'b1;
      else tick();
    end
    act  = readdata_o;
    expv = exp_q.pop_front();
  endtask

  task automatic test_reset();
    logic [31:0] e;
    rst_n_i = 1'b0; read_i = 1'b0; write_i = 1'b0; address_i = '0;
    writedata_i = '0; byteenable_i = '0; test_finished_i = '0; test_result_i = '0;
    repeat (3) tick();
    n_chk++; if (readdatavalid_o !== 1'b0) $display("FAIL rst_rdv: got %b want 0", readdatavalid_o); else n_pass++;
    n_chk++; if (readdata_o !== 32'h0) $display("FAIL rst_rdata: got %h want 0", readdata_o); else n_pass++;
    n_chk++; if (start_o !== 2'b00) $display("FAIL rst_start: got %b want 00", start_o); else n_pass++;
    n_chk++; if (abort_o !== 2'b00) $display("FAIL rst_abort: got %b want 00", abort_o); else n_pass++;
    n_chk++; if (test_param_o !== 256'h0) $display("FAIL rst_param: got %h want 0", test_param_o); else n_pass++;
`ifdef CSR_IRQ_EN
    n_chk++; if (irq_o !== 1'b0) $display("FAIL rst_irq: got %b want 0", irq_o); else n_pass++;
`endif
    rst_n_i = 1'b1;
    tick();
    // Exact two-cycle latency on ch1 PARAM0
    exp_q.push_back(32'h0);
    address_i = 5'h14;
    read_i    = 1'b1;
    tick();
    read_i    = 1'b0;
    n_chk++; if (readdatavalid_o !== 1'b0) $display("FAIL lat_n1: rdv got %b want 0", readdatavalid_o); else n_pass++;
    tick();
    e = exp_q.pop_front();
    n_chk++; if (readdatavalid_o !== 1'b1 || readdata_o !== e)
      $display("FAIL lat_n2: rdv %b data %h want 1 %h", readdatavalid_o, readdata_o, e); else n_pass++;
    tick();
    n_chk++; if (readdatavalid_o !== 1'b0) $display("FAIL lat_n3: rdv got %b want 0", readdatavalid_o); else n_pass++;
  endtask

  task automatic test_param_be();
    bit got; logic [31:0] act, e;
    wr(5'h05, 32'hA5A5_A5A5, 4'hF);
    wr(5'h05, 32'h0000_1200, 4'h2);
    rd_pop(5'h05, 32'hA5A5_12A5, got, act, e);
    n_chk++; if (!got || act !== e) $display("FAIL param_be: got %h (valid %b) want %h", act, got, e); else n_pass++;
    n_chk++; if (test_param_o[63:32] !== 32'hA5A5_12A5)
      $display("FAIL param_out: got %h want a5a512a5", test_param_o[63:32]); else n_pass++;
    wr(5'h05, 32'hFFFF_FFFF, 4'h0);
    rd_pop(5'h05, 32'hA5A5_12A5, got, act, e);
    n_chk++; if (!got || act !== e) $display("FAIL param_be0: got %h (valid %b) want %h", act, got, e); else n_pass++;
  endtask

  task automatic test_start();
    bit got; logic [31:0] act, e;
    wr(5'h10, 32'h1, 4'h1);
    n_chk++; if (start_o !== 2'b10) $display("FAIL start_pulse: got %b want 10", start_o); else n_pass++;
    tick();
    n_chk++; if (start_o !== 2'b00) $display("FAIL start_one: got %b want 00", start_o); else n_pass++;
    rd_pop(5'h11, 32'h1, got, act, e);
    n_chk++; if (!got || act !== e) $display("FAIL start_status: got %h (valid %b) want %h", act, got, e); else n_pass++;
    wr(5'h10, 32'h1, 4'h1);
    n_chk++; if (start_o !== 2'b00) $display("FAIL start_busy: got %b want 00", start_o); else n_pass++;
    wr(5'h14, 32'hDEAD_BEEF, 4'hF);
    rd_pop(5'h14, 32'h0, got, act, e);
    n_chk++; if (!got || act !== e) $display("FAIL param_busy: got %h (valid %b) want %h", act, got, e); else n_pass++;
    n_chk++; if (test_param_o[159:128] !== 32'h0)
      $display("FAIL param_busy_out: got %h want 0", test_param_o[159:128]); else n_pass++;
  endtask

  task automatic test_finish();
    bit got; logic [31:0] act, e;
    test_result_i[128 +: 32] = 32'h0000_0042;
    test_result_i[160 +: 32] = 32'h0000_1111;
    test_finished_i[1] = 1'b1;
    repeat (3) tick();
    rd_pop(5'h11, 32'h2, got, act, e);
    n_chk++; if (!got || act !== e) $display("FAIL fin_status: got %h (valid %b) want %h", act, got, e); else n_pass++;
    rd_pop(5'h18, 32'h42, got, act, e);
    n_chk++; if (!got || act !== e) $display("FAIL fin_res0: got %h (valid %b) want %h", act, got, e); else n_pass++;
    rd_pop(5'h19, 32'h1111, got, act, e);
    n_chk++; if (!got || act !== e) $display("FAIL fin_res1: got %h (valid %b) want %h", act, got, e); else n_pass++;
    rd_pop(5'h11, 32'h0, got, act, e);
    n_chk++; if (!got || act !== e) $display("FAIL fin_clear: got %h (valid %b) want %h", act, got, e); else n_pass++;
    // Edge while idle is ignored; result holds.
    test_result_i[128 +: 32] = 32'h0000_0099;
    test_finished_i[1] = 1'b0;
    repeat (3) tick();
    test_finished_i[1] = 1'b1;
    repeat (3) tick();
    rd_pop(5'h18, 32'h42, got, act, e);
    n_chk++; if (!got || act !== e) $display("FAIL fin_hold: got %h (valid %b) want %h", act, got, e); else n_pass++;
    rd_pop(5'h11, 32'h0, got, act, e);
    n_chk++; if (!got || act !== e) $display("FAIL fin_idle: got %h (valid %b) want %h", act, got, e); else n_pass++;
    test_finished_i[1] = 1'b0;
  endtask

  task automatic test_abort();
    bit got; logic [31:0] act, e;
    wr(5'h00, 32'h1, 4'h1);
    n_chk++; if (start_o !== 2'b01) $display("FAIL abt_start: got %b want 01", start_o); else n_pass++;
    wr(5'h00, 32'h3, 4'h1);
    n_chk++; if (abort_o !== 2'b01) $display("FAIL abt_pulse: got %b want 01", abort_o); else n_pass++;
    n_chk++; if (start_o !== 2'b00) $display("FAIL abt_nostart: got %b want 00", start_o); else n_pass++;
    rd_pop(5'h01, 32'h4, got, act, e);
    n_chk++; if (!got || act !== e) $display("FAIL abt_status: got %h (valid %b) want %h", act, got, e); else n_pass++;
    rd_pop(5'h01, 32'h0, got, act, e);
    n_chk++; if (!got || act !== e) $display("FAIL abt_clear: got %h (valid %b) want %h", act, got, e); else n_pass++;
    wr(5'h00, 32'h2, 4'h1);
    n_chk++; if (abort_o !== 2'b00) $display("FAIL abt_idle: got %b want 00", abort_o); else n_pass++;
    wr(5'h00, 32'h3, 4'h1);
    n_chk++; if (start_o !== 2'b00) $display("FAIL abt_both_idle: got %b want 00", start_o); else n_pass++;
    rd_pop(5'h01, 32'h0, got, act, e);
    n_chk++; if (!got || act !== e) $display("FAIL abt_both_status: got %h (valid %b) want %h", act, got, e); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [4:0]  b_addr [6];
    logic [31:0] b_exp  [6];
    logic [31:0] e;
    int got_cnt = 0;
    b_addr[0] = 5'h05; b_exp[0] = 32'hA5A5_12A5;
    b_addr[1] = 5'h18; b_exp[1] = 32'h0000_0042;
    b_addr[2] = 5'h1C; b_exp[2] = 32'h0;
    b_addr[3] = 5'h03; b_exp[3] = 32'h0;
    b_addr[4] = 5'h11; b_exp[4] = 32'h0;
    b_addr[5] = 5'h02; b_exp[5] = 32'h0;
    for (int i = 0; i < 10; i++) begin
      if (i < 6) begin
        exp_q.push_back(b_exp[i]);
        address_i = b_addr[i];
        read_i    = 1'b1;
      end else begin
        read_i    = 1'b0;
      end
      tick();
      if (readdatavalid_o) begin
        got_cnt++;
        e = exp_q.pop_front();
        n_chk++; if (readdata_o !== e)
          $display("FAIL b2b_data%0d: got %h want %h", got_cnt, readdata_o, e); else n_pass++;
      end
    end
    read_i = 1'b0;
    n_chk++; if (got_cnt !== 6) $display("FAIL b2b_count: got %0d want 6", got_cnt); else n_pass++;
  endtask

  task automatic test_collision();
    bit got; logic [31:0] act, e;
    int spurious = 0;
    address_i = 5'h06; writedata_i = 32'h1234_5678; byteenable_i = 4'hF;
    read_i = 1'b1; write_i = 1'b1;
    tick();
    read_i = 1'b0; write_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (readdatavalid_o) spurious++;
      tick();
    end
    n_chk++; if (spurious !== 0) $display("FAIL coll_rdv: got %0d valids want 0", spurious); else n_pass++;
    rd_pop(5'h06, 32'h1234_5678, got, act, e);
    n_chk++; if (!got || act !== e) $display("FAIL coll_write: got %h (valid %b) want %h", act, got, e); else n_pass++;
  endtask

  task automatic test_irq();
    bit got; logic [31:0] act, e;
`ifdef CSR_IRQ_EN
    n_chk++; if (irq_o !== 1'b0) $display("FAIL irq_idle: got %b want 0", irq_o); else n_pass++;
    wr(5'h02, 32'h1, 4'h1);
    rd_pop(5'h02, 32'h1, got, act, e);
    n_chk++; if (!got || act !== e) $display("FAIL irq_mask_rd: got %h (valid %b) want %h", act, got, e); else n_pass++;
    wr(5'h00, 32'h1, 4'h1);
    test_finished_i[0] = 1'b1;
    repeat (4) tick();
    n_chk++; if (irq_o !== 1'b1) $display("FAIL irq_set: got %b want 1", irq_o); else n_pass++;
    rd_pop(5'h01, 32'h2, got, act, e);
    n_chk++; if (!got || act !== e) $display("FAIL irq_status: got %h (valid %b) want %h", act, got, e); else n_pass++;
    tick();
    n_chk++; if (irq_o !== 1'b0) $display("FAIL irq_clear: got %b want 0", irq_o); else n_pass++;
    test_finished_i[0] = 1'b0;
`else
    wr(5'h02, 32'h1, 4'h1);
    rd_pop(5'h02, 32'h0, got, act, e);
    n_chk++; if (!got || act !== e) $display("FAIL noirq_mask: got %h (valid %b) want %h", act, got, e); else n_pass++;
`endif
  endtask

  task automatic test_reset_mid();
    bit got; logic [31:0] act, e;
    int spurious = 0;
    wr(5'h10, 32'h1, 4'h1);
    address_i = 5'h11;
    read_i    = 1'b1;
    tick();
    read_i    = 1'b0;
    rst_n_i   = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      if (readdatavalid_o || abort_o !== 2'b00) spurious++;
      tick();
    end
    rst_n_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (readdatavalid_o || abort_o !== 2'b00) spurious++;
      tick();
    end
    n_chk++; if (spurious !== 0) $display("FAIL rstmid_drop: got %0d stray events want 0", spurious); else n_pass++;
    rd_pop(5'h11, 32'h0, got, act, e);
    n_chk++; if (!got || act !== e) $display("FAIL rstmid_busy: got %h (valid %b) want %h", act, got, e); else n_pass++;
    rd_pop(5'h05, 32'h0, got, act, e);
    n_chk++; if (!got || act !== e) $display("FAIL rstmid_param: got %h (valid %b) want %h", act, got, e); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_param_be();
    test_start();
    test_finish();
    test_abort();
    test_back_to_back();
    test_collision();
    test_irq();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
